// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: funct3 codes,
// FSM state encoding and operand-signedness decode.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'b000;
   localparam logic [2:0] OP_MULH   = 3'b001;
   localparam logic [2:0] OP_MULHSU = 3'b010;
   localparam logic [2:0] OP_MULHU  = 3'b011;
   localparam logic [2:0] OP_DIV    = 3'b100;
   localparam logic [2:0] OP_DIVU   = 3'b101;
   localparam logic [2:0] OP_REM    = 3'b110;
   localparam logic [2:0] OP_REMU   = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_FIX  = 2'd2,
      ST_FAST = 2'd3
   } state_t;

   // funct3[2] separates the divide class from the multiply class.
   function automatic logic is_div(input logic [2:0] op);
      return op[2];
   endfunction

   // rs1 is treated as signed for MULH, MULHSU, DIV and REM.
   function automatic logic is_signed_a(input logic [2:0] op);
      return op[2] ? ~op[0] : ((op == OP_MULH) || (op == OP_MULHSU));
   endfunction

   // rs2 is treated as signed for MULH, DIV and REM.
   function automatic logic is_signed_b(input logic [2:0] op);
      return op[2] ? ~op[0] : (op == OP_MULH);
   endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Sign handling around the unsigned iteration core: magnitudes and result
// signs on the way in, conditional negation and half/result select on the
// way out. Purely combinational.
module muldiv_sign_fix
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0]   i_a,
   input  logic [XLEN-1:0]   i_b,
   input  logic [2:0]        i_op,
   output logic [XLEN-1:0]   o_abs_a,
   output logic [XLEN-1:0]   o_abs_b,
   output logic              o_neg_q,
   output logic              o_neg_r,
   input  logic [2*XLEN-1:0] i_acc,
   input  logic [2:0]        i_fix_op,
   input  logic              i_fix_neg_q,
   input  logic              i_fix_neg_r,
   output logic [XLEN-1:0]   o_mul,
   output logic [XLEN-1:0]   o_q,
   output logic [XLEN-1:0]   o_rem
);

   logic              w_sa;
   logic              w_sb;
   logic [2*XLEN-1:0] w_prod;

   // Operand side: magnitudes plus product/quotient sign and remainder sign
   // (the remainder takes the dividend's sign).
   always_comb begin
      w_sa    = is_signed_a(i_op) & i_a[XLEN-1];
      w_sb    = is_signed_b(i_op) & i_b[XLEN-1];
      o_abs_a = w_sa ? -i_a : i_a;
      o_abs_b = w_sb ? -i_b : i_b;
      o_neg_q = w_sa ^ w_sb;
      o_neg_r = w_sa;
   end

   // Result side: the product uses the quotient sign flag; MUL takes the low
   // half, all other multiplies the high half.
   always_comb begin
      w_prod = i_fix_neg_q ? -i_acc : i_acc;
      o_mul  = (i_fix_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];
      o_q    = i_fix_neg_q ? -i_acc[XLEN-1:0] : i_acc[XLEN-1:0];
      o_rem  = i_fix_neg_r ? -i_acc[2*XLEN-1:XLEN] : i_acc[2*XLEN-1:XLEN];
   end

endmodule

// File: rtl/muldiv_iter.sv
// Iterative RISC-V M-extension unit (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
// Multiply: shift-add retiring MUL_STEP multiplier bits per cycle.
// Divide: restoring division, one quotient bit per cycle.
// Divide by zero and signed overflow finish in one cycle (FAST state).
// Optional feature: define MULDIV_DIV_CACHE_EN to keep the last completed
// divide's operands and results so an identical divide/remainder is FAST.
// Handshake: start is taken only while busy is low; busy covers CALC and FIX;
// finish is a one-cycle pulse with r valid, never overlapping busy; kill
// returns to IDLE from any state without a finish and dominates start.
// XLEN must be even and >= 8; MUL_STEP must be 1, 2 or 4 and divide XLEN.
module muldiv_iter
   import muldiv_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int MUL_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            kill,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      m,
   output logic            busy,
   output logic            finish,
   output logic [XLEN-1:0] r,
   output logic [1:0]      o_dbg_state
);

   localparam int              CW       = $clog2(XLEN + 1);
   localparam logic [CW-1:0]   LAST_MUL = CW'(XLEN / MUL_STEP - 1);
   localparam logic [CW-1:0]   LAST_DIV = CW'(XLEN - 1);
   localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

   state_t                 r_state;
   state_t                 w_next_state;
   logic [CW-1:0]          r_cnt;
   logic [2*XLEN-1:0]      r_acc;
   logic [XLEN-1:0]        r_md;
   logic [XLEN-1:0]        r_res;
   logic [2:0]             r_op;
   logic                   r_neg_q;
   logic                   r_neg_r;
   logic                   r_fin;

   logic                   w_launch;
   logic                   w_div;
   logic                   w_sgn;
   logic                   w_b_zero;
   logic                   w_ovf;
   logic                   w_hit;
   logic                   w_fast;
   logic                   w_iter_done;
   logic                   w_neg_q;
   logic                   w_neg_r;
   logic [XLEN-1:0]        w_abs_a;
   logic [XLEN-1:0]        w_abs_b;
   logic [XLEN-1:0]        w_fast_q;
   logic [XLEN-1:0]        w_fast_rem;
   logic [XLEN-1:0]        w_fast_res;
   logic [XLEN-1:0]        w_mul_res;
   logic [XLEN-1:0]        w_q;
   logic [XLEN-1:0]        w_rem;
   logic [XLEN-1:0]        w_res;
   logic [XLEN+MUL_STEP-1:0] w_pp;
   logic [XLEN+MUL_STEP-1:0] w_sum;
   logic [2*XLEN-1:0]      w_mul_next;
   logic [2*XLEN-1:0]      w_div_next;
   logic [XLEN:0]          w_diff;

`ifdef MULDIV_DIV_CACHE_EN
   logic                   r_c_valid;
   logic                   r_c_sgn;
   logic [XLEN-1:0]        r_c_a;
   logic [XLEN-1:0]        r_c_b;
   logic [XLEN-1:0]        r_c_q;
   logic [XLEN-1:0]        r_c_rem;
   logic [XLEN-1:0]        r_a;
   logic [XLEN-1:0]        r_b;

   assign w_hit = r_c_valid && (a == r_c_a) && (b == r_c_b) && (w_sgn == r_c_sgn);
`else
   assign w_hit = 1'b0;
`endif

   muldiv_sign_fix #(.XLEN(XLEN)) u_sign_fix (
      .i_a         (a),
      .i_b         (b),
      .i_op        (m),
      .o_abs_a     (w_abs_a),
      .o_abs_b     (w_abs_b),
      .o_neg_q     (w_neg_q),
      .o_neg_r     (w_neg_r),
      .i_acc       (r_acc),
      .i_fix_op    (r_op),
      .i_fix_neg_q (r_neg_q),
      .i_fix_neg_r (r_neg_r),
      .o_mul       (w_mul_res),
      .o_q         (w_q),
      .o_rem       (w_rem)
   );

   // Launch decode and the one-cycle results for special divides.
   always_comb begin
      w_div      = is_div(m);
      w_sgn      = ~m[0];
      w_launch   = ((r_state == ST_IDLE) || (r_state == ST_FAST)) && start && !kill;
      w_b_zero   = (b == '0);
      w_ovf      = w_div && w_sgn && (a == MIN_VAL) && (b == '1);
      w_fast_q   = '1;
      w_fast_rem = a;
      if (w_b_zero) begin
         w_fast_q   = '1;
         w_fast_rem = a;
      end else if (w_ovf) begin
         w_fast_q   = MIN_VAL;
         w_fast_rem = '0;
      end
`ifdef MULDIV_DIV_CACHE_EN
      else if (w_hit) begin
         w_fast_q   = r_c_q;
         w_fast_rem = r_c_rem;
      end
`endif
      w_fast     = w_div && (w_b_zero || w_ovf || w_hit);
      w_fast_res = m[1] ? w_fast_rem : w_fast_q;
   end

   // One shift-add or restoring-divide step on the 2*XLEN working register.
   always_comb begin
      w_pp        = {{MUL_STEP{1'b0}}, r_md} * {{XLEN{1'b0}}, r_acc[MUL_STEP-1:0]};
      w_sum       = {{MUL_STEP{1'b0}}, r_acc[2*XLEN-1:XLEN]} + w_pp;
      w_mul_next  = {w_sum, r_acc[XLEN-1:MUL_STEP]};
      w_diff      = r_acc[2*XLEN-1:XLEN-1] - {1'b0, r_md};
      w_div_next  = w_diff[XLEN] ? {r_acc[2*XLEN-2:0], 1'b0}
                                 : {w_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      w_iter_done = (r_cnt == (is_div(r_op) ? LAST_DIV : LAST_MUL));
      w_res       = is_div(r_op) ? (r_op[1] ? w_rem : w_q) : w_mul_res;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_next_state;
   end

   // FSM next state and busy; kill overrides every transition.
   always_comb begin
      w_next_state = r_state;
      busy         = (r_state == ST_CALC) || (r_state == ST_FIX);
      case (r_state)
         ST_IDLE, ST_FAST: begin
            w_next_state = ST_IDLE;
            if (w_launch) w_next_state = w_fast ? ST_FAST : ST_CALC;
         end
         ST_CALC: if (w_iter_done) w_next_state = ST_FIX;
         ST_FIX:  w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
      if (kill) w_next_state = ST_IDLE;
   end

   // Datapath: latch operands on launch, iterate in CALC, write r in FIX/FAST.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= '0;
         r_acc   <= '0;
         r_md    <= '0;
         r_res   <= '0;
         r_op    <= OP_MUL;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_fin   <= 1'b0;
      end else begin
         r_fin <= 1'b0;
         if (!kill) begin
            case (r_state)
               ST_IDLE, ST_FAST: begin
                  if (w_launch) begin
                     r_op    <= m;
                     r_cnt   <= '0;
                     r_neg_q <= w_neg_q;
                     r_neg_r <= w_neg_r;
                     r_acc   <= w_div ? {{XLEN{1'b0}}, w_abs_a} : {{XLEN{1'b0}}, w_abs_b};
                     r_md    <= w_div ? w_abs_b : w_abs_a;
                     if (w_fast) begin
                        r_res <= w_fast_res;
                        r_fin <= 1'b1;
                     end
                  end
               end
               ST_CALC: begin
                  r_acc <= is_div(r_op) ? w_div_next : w_mul_next;
                  r_cnt <= r_cnt + CW'(1);
               end
               ST_FIX: begin
                  r_res <= w_res;
                  r_fin <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef MULDIV_DIV_CACHE_EN
   // Remember the most recently completed divide: operands, signedness and
   // both quotient and remainder, so either flavour can be served from it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_c_valid <= 1'b0;
         r_c_sgn   <= 1'b0;
         r_c_a     <= '0;
         r_c_b     <= '0;
         r_c_q     <= '0;
         r_c_rem   <= '0;
         r_a       <= '0;
         r_b       <= '0;
      end else if (!kill) begin
         if (w_launch) begin
            r_a <= a;
            r_b <= b;
            if (w_fast) begin
               r_c_valid <= 1'b1;
               r_c_a     <= a;
               r_c_b     <= b;
               r_c_sgn   <= w_sgn;
               r_c_q     <= w_fast_q;
               r_c_rem   <= w_fast_rem;
            end
         end else if ((r_state == ST_FIX) && is_div(r_op)) begin
            r_c_valid <= 1'b1;
            r_c_a     <= r_a;
            r_c_b     <= r_b;
            r_c_sgn   <= ~r_op[0];
            r_c_q     <= w_q;
            r_c_rem   <= w_rem;
         end
      end
   end
`endif

   assign finish      = r_fin;
   assign r           = r_res;
   assign o_dbg_state = r_state;

endmodule
